// File: rtl/p3_controller.sv
// ============================================================================
// Module   : p3_controller
// Purpose  : Multi-cycle FSM that decodes one instruction word and sequences
//            the p3 datapath strobes one micro-step per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module p3_controller #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           in,
    input  logic                  load,
    input  logic                  s,
    output logic                  w,
    output logic                  err,
    output logic [2:0]            readnum,
    output logic [2:0]            writenum,
    output logic                  write,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic                  vsel,
    output logic [1:0]            shift,
    output logic [1:0]            ALUop,
    output logic [DATA_WIDTH-1:0] imm_out
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_RD  = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic        r_err;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_is_mov_imm;
    logic       w_is_mov_reg;
    logic       w_is_alu;
    logic       w_is_mvn;
    logic       w_is_cmp;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu     = (w_opcode == 3'b101);
    assign w_is_mvn     = w_is_alu && (w_op == 2'b11);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // IR only changes while idle, so it is stable for a whole instruction
            if (r_state == S_WAIT && load)
                r_ir <= in;
            if (r_state == S_WAIT && s)
                r_err <= 1'b0;
            else if (r_state == S_DECODE && !w_is_mov_imm && !w_is_mov_reg && !w_is_alu)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_next   = S_WAIT;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (r_state)
            S_WAIT: begin
                w      = 1'b1;
                w_next = s ? S_DECODE : S_WAIT;
            end
            S_DECODE: begin
                if (w_is_mov_imm)
                    w_next = S_WRITE_IMM;
                else if (w_is_mov_reg || w_is_mvn)
                    w_next = S_GET_B;
                else if (w_is_alu)
                    w_next = S_GET_A;
                else
                    w_next = S_WAIT;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = S_GET_B;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                // ALU op field matches the op bits for every legal op (MOV_REG has op=00 -> add)
                shift  = w_sh;
                ALUop  = w_op;
                asel   = w_is_mov_reg || w_is_mvn;
                loads  = w_is_cmp;
                loadc  = !w_is_cmp;
                w_next = w_is_cmp ? S_WAIT : S_WRITE_RD;
            end
            S_WRITE_RD: begin
                writenum = w_rd;
                write    = 1'b1;
                w_next   = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum = w_rn;
                vsel     = 1'b1;
                write    = 1'b1;
                w_next   = S_WAIT;
            end
            default: w_next = S_WAIT;
        endcase
    end

    assign err = r_err;

    generate
        if (DATA_WIDTH > 8) begin : g_sext
            assign imm_out = {{(DATA_WIDTH-8){r_ir[7]}}, r_ir[7:0]};
        end else begin : g_no_sext
            assign imm_out = r_ir[7:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_p3_controller.sv
// ============================================================================
// Module   : tb_p3_controller
// Purpose  : Directed, table-driven self-checking bench for p3_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p3_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] imm_out;

    int total = 0;
    int bad   = 0;

    p3_controller #(.DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
        .w(w), .err(err), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .ALUop(ALUop), .imm_out(imm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic        err;
        int          n_wr;
        logic [2:0]  wnum;
        logic        vsel;
        int          n_la;
        logic [2:0]  rn_a;
        int          n_lb;
        logic [2:0]  rn_b;
        int          n_lc;
        int          n_ls;
        logic [1:0]  ex_sh;
        logic [1:0]  ex_alu;
        logic        ex_asel;
        logic [15:0] imm;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] strobes();
        return {write, loada, loadb, loadc, loads, asel, bsel, vsel,
                readnum, writenum, shift, ALUop, 1'b0, 2'b00};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int         lat, n_wr, n_la, n_lb, n_lc, n_ls, n_bsel;
        logic [2:0] wnum, rn_a, rn_b;
        logic       vs, ex_asel;
        logic [1:0] ex_sh, ex_alu;
        string      p;
        lat = 0; n_wr = 0; n_la = 0; n_lb = 0; n_lc = 0; n_ls = 0; n_bsel = 0;
        wnum = 0; rn_a = 0; rn_b = 0; vs = 0; ex_asel = 0; ex_sh = 0; ex_alu = 0;
        p = $sformatf("v%0d_%h", idx, v.instr);
        in = v.instr; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        while (!w && lat < 12) begin
            if (write) begin n_wr++; wnum = writenum; vs = vsel; end
            if (loada) begin n_la++; rn_a = readnum; end
            if (loadb) begin n_lb++; rn_b = readnum; end
            if (loadc) n_lc++;
            if (loads) n_ls++;
            if (bsel)  n_bsel++;
            if (loadc || loads) begin ex_sh = shift; ex_alu = ALUop; ex_asel = asel; end
            step();
            lat++;
        end
        chk({p, "_lat"}, lat, v.lat);
        chk({p, "_err"}, {31'd0, err}, {31'd0, v.err});
        chk({p, "_nwrite"}, n_wr, v.n_wr);
        chk({p, "_nloada"}, n_la, v.n_la);
        chk({p, "_nloadb"}, n_lb, v.n_lb);
        chk({p, "_nloadc"}, n_lc, v.n_lc);
        chk({p, "_nloads"}, n_ls, v.n_ls);
        chk({p, "_nbsel"}, n_bsel, 0);
        chk({p, "_imm"}, {16'd0, imm_out}, {16'd0, v.imm});
        if (v.n_wr > 0) begin
            chk({p, "_writenum"}, {29'd0, wnum}, {29'd0, v.wnum});
            chk({p, "_vsel"}, {31'd0, vs}, {31'd0, v.vsel});
        end
        if (v.n_la > 0) chk({p, "_rn_a"}, {29'd0, rn_a}, {29'd0, v.rn_a});
        if (v.n_lb > 0) chk({p, "_rn_b"}, {29'd0, rn_b}, {29'd0, v.rn_b});
        if (v.n_lc + v.n_ls > 0) begin
            chk({p, "_shift"}, {30'd0, ex_sh}, {30'd0, v.ex_sh});
            chk({p, "_aluop"}, {30'd0, ex_alu}, {30'd0, v.ex_alu});
            chk({p, "_asel"}, {31'd0, ex_asel}, {31'd0, v.ex_asel});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        //          instr     lat err wr wn vs la ra lb rb lc ls sh     alu    as    imm
        vecs[0] = '{16'hA148, 5, 0, 1, 2, 0, 1, 1, 1, 0, 1, 0, 2'b01, 2'b00, 1'b0, 16'h0048};
        vecs[1] = '{16'hAB04, 4, 0, 0, 0, 0, 1, 3, 1, 4, 0, 1, 2'b00, 2'b01, 1'b0, 16'h0004};
        vecs[2] = '{16'hE000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 16'h0000};
        vecs[3] = '{16'hD2FD, 2, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 16'hFFFD};
        vecs[4] = '{16'hC0B3, 4, 0, 1, 5, 0, 0, 0, 1, 3, 1, 0, 2'b10, 2'b00, 1'b1, 16'hFFB3};
        vecs[5] = '{16'hB6F9, 5, 0, 1, 7, 0, 1, 6, 1, 1, 1, 0, 2'b11, 2'b10, 1'b0, 16'hFFF9};
        vecs[6] = '{16'hC800, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 16'h0000};
        vecs[7] = '{16'hB882, 4, 0, 1, 4, 0, 0, 0, 1, 2, 1, 0, 2'b00, 2'b11, 1'b1, 16'hFF82};
        vecs[8] = '{16'h1234, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 16'h0034};

        reset = 1'b1; in = 16'hFFFF; load = 1'b1; s = 1'b1;
        step();
        step();
        reset = 1'b0; load = 1'b0; s = 1'b0;
        chk("rst_w", {31'd0, w}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_strobes", {9'd0, strobes()}, 32'd0);
        chk("rst_imm", {16'd0, imm_out}, 32'd0);

        for (int i = 0; i < 9; i++)
            run_vec(i, vecs[i]);

        // err from the last illegal vector holds while idle
        step();
        chk("err_hold", {31'd0, err}, 32'd1);

        // load alone in WAIT updates IR without starting
        in = 16'h00F0; load = 1'b1;
        step();
        load = 1'b0;
        chk("load_only_imm", {16'd0, imm_out}, 32'h0000FFF0);
        chk("load_only_w", {31'd0, w}, 32'd1);
        step();
        chk("load_only_idle", {31'd0, w}, 32'd1);

        // held s re-triggers immediately on return to WAIT
        in = 16'hD2FD; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0;
        chk("held_decode_w", {31'd0, w}, 32'd0);
        chk("held_err_clr", {31'd0, err}, 32'd0);
        step();
        chk("held_write", {31'd0, write}, 32'd1);
        step();
        chk("held_wait_w", {31'd0, w}, 32'd1);
        step();
        chk("held_retrig_w", {31'd0, w}, 32'd0);
        s = 1'b0;
        step();
        step();
        chk("held_back_w", {31'd0, w}, 32'd1);
        step();
        chk("held_stays_idle", {31'd0, w}, 32'd1);

        // ignored s/load mid-instruction, then reset during EXEC
        in = 16'hA148; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        step();
        chk("seq_geta_loada", {31'd0, loada}, 32'd1);
        chk("seq_geta_readnum", {29'd0, readnum}, 32'd1);
        s = 1'b1;
        step();
        s = 1'b0;
        chk("seq_getb_loadb", {31'd0, loadb}, 32'd1);
        chk("seq_getb_readnum", {29'd0, readnum}, 32'd0);
        in = 16'h5555; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk("seq_exec_loadc", {31'd0, loadc}, 32'd1);
        chk("seq_exec_shift", {30'd0, shift}, 32'd1);
        chk("seq_exec_aluop", {30'd0, ALUop}, 32'd0);
        chk("seq_ir_stable", {16'd0, imm_out}, 32'h00000048);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_w", {31'd0, w}, 32'd1);
        chk("midrst_strobes", {9'd0, strobes()}, 32'd0);
        chk("midrst_imm", {16'd0, imm_out}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst_nowrite_%0d", k), {31'd0, write}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
